mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
- Multicycle MIPS controller FSM. It sequences the shared datapath (one ALU, one memory, register file, PC/IR) through fetch, decode, execute and writeback.
- Drives the 3-bit ALU function code F, the mux selects and the write enables each cycle, from the IR opcode/funct fields and the ALU zero flag.
- Sits beside the datapath inside the multicycle processor top.

Parameters:
UNKNOWN_OP_TRAP, 0, 0: unsupported opcode in DECODE returns to FETCH; 1: enters TRAP state and holds there until reset.

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high
op  input  6  instr[31:26] from IR
funct  input  6  instr[5:0] from IR
zero  input  1  ALU Z flag (result == 0)
pcen  output  1  PC register enable
iord  output  1  memory address select: 0 = PC, 1 = ALUOut
memwrite  output  1  data memory write
irwrite  output  1  IR load
regdst  output  1  write register: 0 = rt, 1 = rd
memtoreg  output  1  writeback data: 0 = ALUOut, 1 = MDR
regwrite  output  1  register file write
alusrca  output  1  ALU A: 0 = PC, 1 = regA
alusrcb  output  2  ALU B: 00 = regB, 01 = const 4, 10 = SignImm, 11 = SignImm<<2
pcsrc  output  2  PC next: 00 = ALUResult, 01 = ALUOut, 10 = jump target
alucontrol  output  3  ALU F: 010 add, 110 sub, 000 and, 001 or, 111 slt
illegal  output  1  high while in TRAP

Behaviour:
- Moore FSM, 4-bit state register.
- Outputs are combinational from state. Exception: alucontrol in RTYPEEX is also a function of funct. pcen is also a function of zero.
- Control signals not listed for a state are 0.
- Reset:
  - reset high at a clock edge -> state = FETCH next cycle.
  - While reset is high, pcen, irwrite, memwrite and regwrite are forced 0. All other outputs take their FETCH values.
  - Reset mid-instruction abandons that instruction. No partial writeback is issued after the reset edge.
- Opcodes: lw 100011, sw 101011, R-type 000000, beq 000100, addi 001000, j 000010.
- State outputs and transitions:
  - FETCH: irwrite=1, pcwrite=1, alusrcb=01, alucontrol=010, pcsrc=00. -> DECODE.
  - DECODE: alusrcb=11, alucontrol=010 (branch target into ALUOut). Next state by opcode:
    - lw/sw -> MEMADR
    - R-type -> RTYPEEX
    - beq -> BEQEX
    - addi -> ADDIEX
    - j -> JEX
    - other -> FETCH, or TRAP when UNKNOWN_OP_TRAP=1
  - MEMADR: alusrca=1, alusrcb=10, alucontrol=010. lw -> MEMRD; sw -> MEMWR.
  - MEMRD: iord=1. -> MEMWB.
  - MEMWB: regwrite=1, memtoreg=1, regdst=0. -> FETCH.
  - MEMWR: iord=1, memwrite=1. -> FETCH.
  - RTYPEEX: alusrca=1, alusrcb=00. alucontrol from funct:
    - 100000 -> 010
    - 100010 -> 110
    - 100100 -> 000
    - 100101 -> 001
    - 101010 -> 111
    - any other funct -> 010
    - -> RTYPEWB.
  - RTYPEWB: regwrite=1, regdst=1, memtoreg=0. -> FETCH.
  - BEQEX: alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01, branch=1. -> FETCH.
  - ADDIEX: alusrca=1, alusrcb=10, alucontrol=010. -> ADDIWB.
  - ADDIWB: regwrite=1, regdst=0, memtoreg=0. -> FETCH.
  - JEX: pcsrc=10, pcwrite=1. -> FETCH.
  - TRAP: illegal=1, all enables 0. Stays in TRAP until reset.
- pcen = pcwrite | (branch & zero). pcwrite and branch are internal only.
- Instruction latency in cycles: lw 5; sw 4; R-type 4; addi 4; beq 3; j 3.
- Unencoded state values are treated as FETCH: all enables 0, next state = FETCH.

Optional Feature:
- Macro: MIPS_CTRL_BNE_EN.
- Defined:
  - opcode 000101 (bne) in DECODE -> BNEEX.
  - BNEEX outputs: alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01, branchne=1. -> FETCH.
  - pcen = pcwrite | (branch & zero) | (branchne & ~zero).
- Undefined:
  - BNEEX state and branchne do not exist.
  - opcode 000101 is handled as unsupported: -> FETCH, or TRAP when UNKNOWN_OP_TRAP=1.

Test Plan:
- reset=1 for 2 cycles, then release -> pcen=irwrite=memwrite=regwrite=0 during reset. First post-reset cycle is FETCH: irwrite=1, pcen=1, alusrcb=01, alucontrol=010.
- lw (op=100011) -> sequence FETCH, DECODE, MEMADR (alusrcb=10), MEMRD (iord=1), MEMWB (regwrite=1, memtoreg=1). regwrite high for exactly 1 cycle; next FETCH on cycle 6.
- R-type with funct 100010, then 101010, then 110000 -> RTYPEEX alucontrol = 110, 111 and 010 respectively. RTYPEWB has regdst=1, regwrite=1.
- beq with zero=1, then beq with zero=0 -> pcen=1, pcsrc=01 in BEQEX for the first; pcen=0 for the second. Both return to FETCH after 3 cycles.
- op=111111 with UNKNOWN_OP_TRAP=0 -> FETCH after DECODE, no writes. With UNKNOWN_OP_TRAP=1 -> illegal=1, held for 10+ cycles until reset.
- reset asserted during RTYPEEX -> no regwrite pulse follows; state = FETCH after reset is released. With MIPS_CTRL_BNE_EN: bne with zero=0 -> pcen=1 in BNEEX.

Source files
------------

// File: rtl/mips_multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : mips_multicycle_ctrl_if
// Brief   : IR fields / zero flag in, datapath control strobes out.
// Rev     : 1.0  initial release
// ============================================================================
interface mips_multicycle_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcen;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic       illegal;

    // master: the controller; slave: the datapath it steers
    modport master (
        input  op, funct, zero,
        output pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, alucontrol, illegal
    );
    modport slave (
        output op, funct, zero,
        input  pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, alucontrol, illegal
    );
endinterface
`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : mips_multicycle_ctrl
// Brief   : Multicycle MIPS control FSM; MIPS_CTRL_BNE_EN adds bne support.
// Rev     : 1.0  initial release
// ============================================================================
module mips_multicycle_ctrl #(
    parameter int UNKNOWN_OP_TRAP = 0
) (
    input  wire logic                   clk,
    input  wire logic                   reset,
    mips_multicycle_ctrl_if.master      bus
);
    localparam logic [3:0] c_st_fetch   = 4'd0;
    localparam logic [3:0] c_st_decode  = 4'd1;
    localparam logic [3:0] c_st_memadr  = 4'd2;
    localparam logic [3:0] c_st_memrd   = 4'd3;
    localparam logic [3:0] c_st_memwb   = 4'd4;
    localparam logic [3:0] c_st_memwr   = 4'd5;
    localparam logic [3:0] c_st_rtypeex = 4'd6;
    localparam logic [3:0] c_st_rtypewb = 4'd7;
    localparam logic [3:0] c_st_beqex   = 4'd8;
    localparam logic [3:0] c_st_addiex  = 4'd9;
    localparam logic [3:0] c_st_addiwb  = 4'd10;
    localparam logic [3:0] c_st_jex     = 4'd11;
    localparam logic [3:0] c_st_trap    = 4'd12;
`ifdef MIPS_CTRL_BNE_EN
    localparam logic [3:0] c_st_bneex   = 4'd13;
`endif

    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_addi  = 6'b001000;
    localparam logic [5:0] c_op_j     = 6'b000010;
`ifdef MIPS_CTRL_BNE_EN
    localparam logic [5:0] c_op_bne   = 6'b000101;
`endif
    localparam logic [3:0] c_st_unknown = (UNKNOWN_OP_TRAP != 0) ? c_st_trap : c_st_fetch;

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic       w_pcwrite;
    logic       w_branch;
    logic       w_branchne;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_fetch;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = c_st_fetch;
        case (r_state)
            c_st_fetch:   w_next = c_st_decode;
            c_st_decode: begin
                case (bus.op)
                    c_op_lw, c_op_sw: w_next = c_st_memadr;
                    c_op_rtype:       w_next = c_st_rtypeex;
                    c_op_beq:         w_next = c_st_beqex;
                    c_op_addi:        w_next = c_st_addiex;
                    c_op_j:           w_next = c_st_jex;
`ifdef MIPS_CTRL_BNE_EN
                    c_op_bne:         w_next = c_st_bneex;
`endif
                    default:          w_next = c_st_unknown;
                endcase
            end
            c_st_memadr:  w_next = (bus.op == c_op_sw) ? c_st_memwr : c_st_memrd;
            c_st_memrd:   w_next = c_st_memwb;
            c_st_rtypeex: w_next = c_st_rtypewb;
            c_st_addiex:  w_next = c_st_addiwb;
            c_st_trap:    w_next = c_st_trap;
            default:      w_next = c_st_fetch;
        endcase
    end

    always_comb begin
        bus.iord       = 1'b0;
        bus.memwrite   = 1'b0;
        bus.irwrite    = 1'b0;
        bus.regdst     = 1'b0;
        bus.memtoreg   = 1'b0;
        bus.regwrite   = 1'b0;
        bus.alusrca    = 1'b0;
        bus.alusrcb    = 2'b00;
        bus.pcsrc      = 2'b00;
        bus.alucontrol = 3'b000;
        bus.illegal    = 1'b0;
        w_pcwrite      = 1'b0;
        w_branch       = 1'b0;
        w_branchne     = 1'b0;
        case (r_state)
            c_st_fetch: begin
                bus.irwrite    = 1'b1;
                w_pcwrite      = 1'b1;
                bus.alusrcb    = 2'b01;
                bus.alucontrol = 3'b010;
            end
            c_st_decode: begin
                bus.alusrcb    = 2'b11;
                bus.alucontrol = 3'b010;
            end
            c_st_memadr, c_st_addiex: begin
                bus.alusrca    = 1'b1;
                bus.alusrcb    = 2'b10;
                bus.alucontrol = 3'b010;
            end
            c_st_memrd:  bus.iord = 1'b1;
            c_st_memwb: begin
                bus.regwrite = 1'b1;
                bus.memtoreg = 1'b1;
            end
            c_st_memwr: begin
                bus.iord     = 1'b1;
                bus.memwrite = 1'b1;
            end
            c_st_rtypeex: begin
                bus.alusrca = 1'b1;
                case (bus.funct)
                    6'b100010: bus.alucontrol = 3'b110;
                    6'b100100: bus.alucontrol = 3'b000;
                    6'b100101: bus.alucontrol = 3'b001;
                    6'b101010: bus.alucontrol = 3'b111;
                    default:   bus.alucontrol = 3'b010;
                endcase
            end
            c_st_rtypewb: begin
                bus.regwrite = 1'b1;
                bus.regdst   = 1'b1;
            end
            c_st_beqex: begin
                bus.alusrca    = 1'b1;
                bus.alucontrol = 3'b110;
                bus.pcsrc      = 2'b01;
                w_branch       = 1'b1;
            end
`ifdef MIPS_CTRL_BNE_EN
            c_st_bneex: begin
                bus.alusrca    = 1'b1;
                bus.alucontrol = 3'b110;
                bus.pcsrc      = 2'b01;
                w_branchne     = 1'b1;
            end
`endif
            c_st_addiwb: bus.regwrite = 1'b1;
            c_st_jex: begin
                bus.pcsrc = 2'b10;
                w_pcwrite = 1'b1;
            end
            c_st_trap:   bus.illegal = 1'b1;
            default: ;
        endcase

        // During reset the outputs mirror FETCH with every write strobe held low
        if (reset) begin
            bus.iord       = 1'b0;
            bus.memwrite   = 1'b0;
            bus.irwrite    = 1'b0;
            bus.regdst     = 1'b0;
            bus.memtoreg   = 1'b0;
            bus.regwrite   = 1'b0;
            bus.alusrca    = 1'b0;
            bus.alusrcb    = 2'b01;
            bus.pcsrc      = 2'b00;
            bus.alucontrol = 3'b010;
            bus.illegal    = 1'b0;
            w_pcwrite      = 1'b0;
            w_branch       = 1'b0;
            w_branchne     = 1'b0;
        end
        bus.pcen = w_pcwrite | (w_branch & bus.zero) | (w_branchne & ~bus.zero);
    end
endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_mips_multicycle_ctrl
// Brief   : Scoreboard bench running a no-trap and a trap controller in lockstep.
// Rev     : 1.0  initial release
// ============================================================================
module tb_mips_multicycle_ctrl;
    // {pcen,iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,alusrcb,pcsrc,alucontrol,illegal}
    localparam logic [15:0] c_rst    = 16'h0044;
    localparam logic [15:0] c_fetch  = 16'h9044;
    localparam logic [15:0] c_decode = 16'h00C4;
    localparam logic [15:0] c_memadr = 16'h0184;
    localparam logic [15:0] c_memrd  = 16'h4000;
    localparam logic [15:0] c_memwb  = 16'h0600;
    localparam logic [15:0] c_memwr  = 16'h6000;
    localparam logic [15:0] c_rt_sub = 16'h010C;
    localparam logic [15:0] c_rt_slt = 16'h010E;
    localparam logic [15:0] c_rt_add = 16'h0104;
    localparam logic [15:0] c_rtwb   = 16'h0A00;
    localparam logic [15:0] c_br_tk  = 16'h811C;
    localparam logic [15:0] c_br_nt  = 16'h011C;
    localparam logic [15:0] c_addiwb = 16'h0200;
    localparam logic [15:0] c_jex    = 16'h8020;
    localparam logic [15:0] c_trap   = 16'h0001;

    localparam logic [5:0] c_lw = 6'b100011, c_sw = 6'b101011, c_rt = 6'b000000;
    localparam logic [5:0] c_beq = 6'b000100, c_addi = 6'b001000, c_j = 6'b000010;
    localparam logic [5:0] c_bad = 6'b111111;

    typedef struct {
        string       name;
        logic [15:0] e0;
        logic [15:0] e1;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    exp_t sb[$];

    mips_multicycle_ctrl_if ifc0 ();
    mips_multicycle_ctrl_if ifc1 ();

    mips_multicycle_ctrl #(.UNKNOWN_OP_TRAP(0)) u_dut0 (.clk(clk), .reset(reset), .bus(ifc0.master));
    mips_multicycle_ctrl #(.UNKNOWN_OP_TRAP(1)) u_dut1 (.clk(clk), .reset(reset), .bus(ifc1.master));

    logic [15:0] w_act0;
    logic [15:0] w_act1;
    assign w_act0 = {ifc0.pcen, ifc0.iord, ifc0.memwrite, ifc0.irwrite, ifc0.regdst, ifc0.memtoreg,
                     ifc0.regwrite, ifc0.alusrca, ifc0.alusrcb, ifc0.pcsrc, ifc0.alucontrol, ifc0.illegal};
    assign w_act1 = {ifc1.pcen, ifc1.iord, ifc1.memwrite, ifc1.irwrite, ifc1.regdst, ifc1.memtoreg,
                     ifc1.regwrite, ifc1.alusrca, ifc1.alusrcb, ifc1.pcsrc, ifc1.alucontrol, ifc1.illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input logic rst, input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input string nm, input logic [15:0] e0, input logic [15:0] e1);
        exp_t item;
        @(posedge clk);
        #1;
        reset = rst;
        ifc0.op = op;  ifc0.funct = fn;  ifc0.zero = z;
        ifc1.op = op;  ifc1.funct = fn;  ifc1.zero = z;
        item.name = nm;
        item.e0   = e0;
        item.e1   = e1;
        sb.push_back(item);
    endtask

    task automatic instr(input logic [5:0] op, input logic [5:0] fn, input logic z, input string nm,
                         input logic [15:0] ex, input logic [15:0] wb, input int n);
        cyc(0, op, fn, ~z, {nm, "_fetch"}, c_fetch, c_fetch);
        cyc(0, op, fn, z,  {nm, "_decode"}, c_decode, c_decode);
        if (n >= 3) cyc(0, op, fn, z, {nm, "_ex"}, ex, ex);
        if (n >= 4) cyc(0, op, fn, z, {nm, "_wb"}, wb, wb);
    endtask

    // Monitor: one output vector per cycle, compared mid-cycle
    initial begin
        exp_t item;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                item = sb.pop_front();
                checks += 2;
                if (w_act0 !== item.e0) begin
                    errors++;
                    $display("FAIL %s trap0: got %h expected %h", item.name, w_act0, item.e0);
                end
                if (w_act1 !== item.e1) begin
                    errors++;
                    $display("FAIL %s trap1: got %h expected %h", item.name, w_act1, item.e1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        ifc0.op = 6'd0;  ifc0.funct = 6'd0;  ifc0.zero = 1'b0;
        ifc1.op = 6'd0;  ifc1.funct = 6'd0;  ifc1.zero = 1'b0;

        cyc(1, c_rt, 6'd0, 1'b0, "reset0", c_rst, c_rst);
        cyc(1, c_rt, 6'd0, 1'b1, "reset1", c_rst, c_rst);

        cyc(0, c_lw, 6'd0, 1'b0, "lw_fetch",  c_fetch,  c_fetch);
        cyc(0, c_lw, 6'd0, 1'b1, "lw_decode", c_decode, c_decode);
        cyc(0, c_lw, 6'd0, 1'b0, "lw_memadr", c_memadr, c_memadr);
        cyc(0, c_lw, 6'd0, 1'b1, "lw_memrd",  c_memrd,  c_memrd);
        cyc(0, c_lw, 6'd0, 1'b0, "lw_memwb",  c_memwb,  c_memwb);

        cyc(0, c_sw, 6'd0, 1'b1, "sw_fetch",  c_fetch,  c_fetch);
        cyc(0, c_sw, 6'd0, 1'b0, "sw_decode", c_decode, c_decode);
        cyc(0, c_sw, 6'd0, 1'b1, "sw_memadr", c_memadr, c_memadr);
        cyc(0, c_sw, 6'd0, 1'b0, "sw_memwr",  c_memwr,  c_memwr);

        instr(c_rt, 6'b100010, 1'b0, "r_sub", c_rt_sub, c_rtwb, 4);
        instr(c_rt, 6'b101010, 1'b1, "r_slt", c_rt_slt, c_rtwb, 4);
        instr(c_rt, 6'b110000, 1'b0, "r_oth", c_rt_add, c_rtwb, 4);
        instr(c_addi, 6'b100010, 1'b1, "addi", c_memadr, c_addiwb, 4);
        instr(c_beq, 6'd0, 1'b1, "beq_z1", c_br_tk, 16'h0, 3);
        instr(c_beq, 6'd0, 1'b0, "beq_z0", c_br_nt, 16'h0, 3);
        instr(c_j, 6'd0, 1'b1, "jump", c_jex, 16'h0, 3);
`ifdef MIPS_CTRL_BNE_EN
        instr(6'b000101, 6'd0, 1'b0, "bne_z0", c_br_tk, 16'h0, 3);
        instr(6'b000101, 6'd0, 1'b1, "bne_z1", c_br_nt, 16'h0, 3);
`endif

        cyc(0, c_bad, 6'd0, 1'b0, "bad_fetch",  c_fetch,  c_fetch);
        cyc(0, c_bad, 6'd0, 1'b1, "bad_decode", c_decode, c_decode);
        for (int i = 0; i < 12; i++) begin
            cyc(0, c_bad, 6'd0, i[0], "bad_hold", (i % 2 == 0) ? c_fetch : c_decode, c_trap);
        end
        cyc(1, c_bad, 6'd0, 1'b0, "trap_reset", c_rst, c_rst);

        cyc(0, c_rt, 6'b100000, 1'b0, "abort_fetch",  c_fetch,  c_fetch);
        cyc(0, c_rt, 6'b100000, 1'b0, "abort_decode", c_decode, c_decode);
        cyc(1, c_rt, 6'b100000, 1'b0, "abort_rtex",   c_rst,    c_rst);
        instr(c_j, 6'd0, 1'b0, "post_j", c_jex, 16'h0, 3);
        cyc(0, c_lw, 6'd0, 1'b0, "final_fetch", c_fetch, c_fetch);

        @(posedge clk);
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
